grf_wb_arbiter: RTL
===================

# grf_wb_arbiter

Arbiter for the single GRF write port. It shares the port between the pipeline W-stage writeback, which has priority, and the multiply/divide unit (MDU) result path. MDU results wait in a 2-entry FIFO. A starvation counter forces a one-cycle pipeline stall so queued MDU results always drain. The block sits between the W stage / MDU and the GRF write inputs (WE, A3, WD3, PC).

## Interface
- STARVE_LIMIT, 4: consecutive cycles a FIFO head may wait before a forced drain; legal range 1..15.
- DEPTH, 2: MDU FIFO depth; power of 2, at least 2.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- p_we  in  1  pipeline W-stage write request
- p_a3  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- p_pc  in  32  pipeline instruction PC, passed through for the write log
- m_valid  in  1  MDU result valid
- m_ready  out  1  FIFO can accept an MDU result
- m_a3  in  5  MDU destination register
- m_wd  in  32  MDU result data
- m_pc  in  32  PC of the MDU instruction
- stall_pipe  out  1  pipeline must hold its W stage this cycle
- busy_mask  out  32  bit i set while a queued MDU result targets register i
- grf_we  out  1  to GRF WE
- grf_a3  out  5  to GRF A3
- grf_wd  out  32  to GRF WD3
- grf_pc  out  32  to GRF PC

## Operation
- An MDU push occurs when m_valid && m_ready. m_ready = !full && !reset.
- m_ready is computed from the current occupancy, so a pop in the same cycle does not free the slot.
- A pushed entry is never granted in the same cycle it is pushed. There is no bypass.
- Grant priority per cycle:
  - When stall_pipe=0 and p_we=1, the pipeline is granted and the FIFO holds.
  - Otherwise, when the FIFO is non-empty, the head is granted and popped.
  - Otherwise there is no grant.
- While stall_pipe=1, p_we is ignored. The pipeline must present the same W-stage request again the next cycle.
- Grant outputs: grf_a3, grf_wd and grf_pc come from the granted source.
- grf_we = grant && (a3 != 0). A write to $0 is consumed (popped, or counted as the pipeline's write) but never asserted to the GRF.
- With no grant: grf_we=0 and grf_a3/grf_wd/grf_pc=0.
- busy_mask is the OR of one-hot(a3) over valid FIFO entries. Bit 0 is always 0.
- External hazard logic stalls any instruction that reads or writes a register flagged in busy_mask. The arbiter does not reorder same-register writes itself.
- FSM states (encoding in the package):
  - IDLE: FIFO empty, counter 0.
  - WAIT: FIFO non-empty, head not yet drained.
  - FORCE: stall_pipe=1; the head is guaranteed to pop this cycle.
- Transitions:
  - IDLE→WAIT on a push.
  - WAIT: the counter increments each cycle the head is present and not popped, and resets to 0 on every pop. WAIT→FORCE when the counter reaches STARVE_LIMIT. WAIT→IDLE when the last entry pops with no push.
  - FORCE→WAIT if entries remain after the pop. FORCE→IDLE if empty. The counter clears on leaving FORCE.
- stall_pipe = (state == FORCE), decoded from registered state.

## Timing
- The grant path is combinational: the GRF writes the granted data at the same rising edge that commits the pop.
- Minimum MDU latency is 1 cycle: push at edge N, GRF write at edge N+1 if the pipeline is idle.
- Maximum head wait is STARVE_LIMIT+1 cycles from becoming head until it is written.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged and busy_mask updates for both entries at the same edge.
- Reset:
  - While reset is high, all of these are 0: grf_we, grf_a3, grf_wd, grf_pc, m_ready, stall_pipe, busy_mask.
  - After the reset edge: FIFO empty, counter 0, state IDLE.
  - A reset mid-FORCE or with queued entries discards them; they are not written.

## Structure
- The shared package holds:
  - State encoding for IDLE, WAIT and FORCE.
  - REG_ZERO = 5'd0.
  - Data/PC width constant, 32.
  - Register address width constant, 5.
- Sub-module wb_fifo:
  - Parameterised DEPTH, synchronous-reset circular buffer of {a3, wd, pc}.
  - Ports: push, pop, full, empty, head, plus per-entry valid/a3 vectors used for busy_mask.
- The top holds the arbitration mux, FSM, starvation counter and busy_mask reduction.

## Test plan
- Pipeline only: p_we=1, p_a3=5, p_wd=0x1234 for 3 cycles, no MDU traffic → grf_we=1 each cycle, grf_a3=5, stall_pipe stays 0.
- MDU uncontended: push a3=8, wd=0xDEAD at edge N, p_we=0 → grf_we=1, grf_a3=8 at edge N+1; busy_mask bit 8 set only between those edges.
- Starvation: push a3=9, then hold p_we=1 continuously with STARVE_LIMIT=4 → stall_pipe=1 exactly one cycle, 4 cycles after the push, in which grf_a3=9; pipeline writes resume the next cycle.
- Full FIFO: two pushes (a3=3, 4) while p_we=1 → m_ready=0 on the third attempt. An attempted push with a simultaneous pop is still refused. Drain order is 3 then 4.
- $0 and reset: push a3=0 → popped with grf_we=0 and busy_mask unaffected. Then queue a3=7 and assert reset for 1 cycle → no write to register 7; all outputs are 0 during reset and m_ready=1 afterwards.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_arbiter_pkg
// Shared types and constants for the GRF writeback arbiter.
// - Widths of register addresses and of data/PC words.
// - REG_ZERO, the hard-wired $0.
// - The state encoding of the arbiter FSM.
// - The FIFO entry layout.
// - reg_onehot(), which builds the busy_mask contribution of a single entry.
package grf_wb_arbiter_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

  // $0 never shows up as busy; its writes are discarded anyway.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a3);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (a3 != REG_ZERO) v[a3] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if
// Bundles the signals around the GRF write port arbiter.
// Groups:
// - Pipeline W-stage request: p_we, p_a3, p_wd, p_pc.
// - MDU result handshake: m_valid, m_ready, m_a3, m_wd, m_pc.
// - Status: stall_pipe and busy_mask.
// - GRF write port: grf_we, grf_a3, grf_wd, grf_pc.
// Modports:
// - slave: the arbiter's view of these signals.
// - master: the view of whatever surrounds the arbiter.
interface grf_wb_arbiter_if;
  import grf_wb_arbiter_pkg::*;

  logic                p_we;
  logic [ADDR_W-1:0]   p_a3;
  logic [DATA_W-1:0]   p_wd;
  logic [DATA_W-1:0]   p_pc;

  logic                m_valid;
  logic                m_ready;
  logic [ADDR_W-1:0]   m_a3;
  logic [DATA_W-1:0]   m_wd;
  logic [DATA_W-1:0]   m_pc;

  logic                stall_pipe;
  logic [NUM_REGS-1:0] busy_mask;

  logic                grf_we;
  logic [ADDR_W-1:0]   grf_a3;
  logic [DATA_W-1:0]   grf_wd;
  logic [DATA_W-1:0]   grf_pc;

  modport slave (
    input  p_we, p_a3, p_wd, p_pc,
    input  m_valid, m_a3, m_wd, m_pc,
    output m_ready, stall_pipe, busy_mask,
    output grf_we, grf_a3, grf_wd, grf_pc
  );

  modport master (
    output p_we, p_a3, p_wd, p_pc,
    output m_valid, m_a3, m_wd, m_pc,
    input  m_ready, stall_pipe, busy_mask,
    input  grf_we, grf_a3, grf_wd, grf_pc
  );

endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// wb_fifo
// Circular buffer of pending MDU results {a3, wd, pc}.
// - DEPTH is a power of 2, at least 2.
// - Reset is synchronous and active-high.
// Ports:
// - clk, reset: clock and synchronous reset.
// - push, push_data: write an entry; ignored when full.
// - pop: drop the head; ignored when empty.
// - full, empty: occupancy flags.
// - head: the oldest entry.
// - entry_valid, entry_a3: per-slot valid bits and destinations, used for busy_mask.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_a3
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Each slot keeps its own valid bit. Because of that, full and empty can be
  // read straight off the slot under each pointer, with no separate count.
  assign empty       = !valid_q[rd_ptr_q];
  assign full        = valid_q[wr_ptr_q];
  assign head        = mem_q[rd_ptr_q];
  assign entry_valid = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_a3[i] = mem_q[i].a3;
  end

  // When push and pop happen together, they always touch different slots:
  // - a pop requires the FIFO to be non-empty;
  // - a push requires it to be non-full;
  // - with both conditions true, the two pointers differ.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop && !empty) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push && !full) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = push_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // The payload needs no reset. Valid bits decide whether it is ever looked at.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
// Shares the single GRF write port between two sources:
// - the pipeline W stage, which has priority;
// - queued MDU results.
// A starvation counter forces a one-cycle pipeline stall. This stops the FIFO
// head from waiting forever.
// Parameters:
// - STARVE_LIMIT (1..15): consecutive un-popped cycles allowed before a forced drain.
// - DEPTH: MDU FIFO depth.
// Ports:
// - clk, reset: clock and synchronous, active-high reset.
// - bus: the grf_wb_arbiter_if slave modport, carrying:
//   - the pipeline request and the MDU handshake;
//   - stall_pipe and busy_mask;
//   - the GRF write port.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH        = 2
) (
  input  logic             clk,
  input  logic             reset,
  grf_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                         fifo_full, fifo_empty;
  wb_entry_t                    head, push_entry;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_a3;

  logic m_ready, stall, push, pop, p_grant, m_grant, last_entry;

  // All handshakes are gated by reset. That way nothing is accepted or written
  // while reset is asserted, even though the state only clears at the edge.
  assign m_ready    = !fifo_full && !reset;
  assign stall      = (state_q == ST_FORCE) && !reset;
  assign push       = bus.m_valid && m_ready;
  assign p_grant    = !stall && bus.p_we && !reset;
  assign m_grant    = !p_grant && !fifo_empty && !reset;
  assign pop        = m_grant;
  assign last_entry = ($countones(entry_valid) == 1);

  assign bus.m_ready    = m_ready;
  assign bus.stall_pipe = stall;

  always_comb begin
    push_entry.a3 = bus.m_a3;
    push_entry.wd = bus.m_wd;
    push_entry.pc = bus.m_pc;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_entry),
    .pop         (pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (head),
    .entry_valid (entry_valid),
    .entry_a3    (entry_a3)
  );

  // Write-port mux. A grant to $0 still consumes the request, but WE stays low.
  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = '0;
    bus.grf_wd = '0;
    bus.grf_pc = '0;
    if (p_grant) begin
      bus.grf_we = (bus.p_a3 != REG_ZERO);
      bus.grf_a3 = bus.p_a3;
      bus.grf_wd = bus.p_wd;
      bus.grf_pc = bus.p_pc;
    end else if (m_grant) begin
      bus.grf_we = (head.a3 != REG_ZERO);
      bus.grf_a3 = head.a3;
      bus.grf_wd = head.wd;
      bus.grf_pc = head.pc;
    end
  end

  always_comb begin
    bus.busy_mask = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i]) bus.busy_mask = bus.busy_mask | reg_onehot(entry_a3[i]);
      end
    end
  end

  // The counter measures how long the current head has gone without popping.
  // - Reaching LIMIT moves the FSM to FORCE. In FORCE, stall_pipe blocks the
  //   pipeline, so the head is granted on the next cycle.
  // - Leaving the FIFO empty returns the FSM to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (push) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          cnt_d = '0;
          if (last_entry && !push) state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == LIMIT) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        cnt_d   = '0;
        state_d = (last_entry && !push) ? ST_IDLE : ST_WAIT;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
